// File: rtl/uart_sys_pkg.sv
// Shared encodings and default opcodes for the UART command path.
package uart_sys_pkg;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_WR_ADDR = 3'b001;
    localparam logic [2:0] ST_WR_DATA = 3'b010;
    localparam logic [2:0] ST_RD_ADDR = 3'b011;
    localparam logic [2:0] ST_RD_WAIT = 3'b100;
    localparam logic [2:0] ST_TX_SEND = 3'b101;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        WR_ADDR = ST_WR_ADDR,
        WR_DATA = ST_WR_DATA,
        RD_ADDR = ST_RD_ADDR,
        RD_WAIT = ST_RD_WAIT,
        TX_SEND = ST_TX_SEND
    } cmd_state_t;

    localparam logic [7:0] WR_CMD_DEF = 8'hAA;
    localparam logic [7:0] RD_CMD_DEF = 8'hBB;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter; only built when FRAME_TIMEOUT_EN is defined.
module uart_cmd_timer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    input  logic clr,
    output logic expired
);

    logic [15:0] cnt;

    assign expired = run && !clr
                  && (cnt == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (!run || clr || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Decodes received bytes into register-file write/read commands.
// Optional inter-byte timeout: define FRAME_TIMEOUT_EN.
module uart_rx_cmd_ctrl
    import uart_sys_pkg::*;
#(
    parameter int          WIDTH          = 8,
    parameter int          ADDR_WIDTH     = 4,
    parameter logic [7:0]  WR_CMD         = WR_CMD_DEF,
    parameter logic [7:0]  RD_CMD         = RD_CMD_DEF,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic                  RF_WrEn,
    output logic [WIDTH-1:0]      RF_WrData,
    output logic                  RF_RdEn,
    input  logic [WIDTH-1:0]      RF_RdData,
    input  logic                  RF_RdData_Valid,
    output logic [WIDTH-1:0]      TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_Busy,
    output logic                  Cmd_Err
);

    cmd_state_t            state, state_n;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_n, rf_addr_n;
    logic [WIDTH-1:0]      wr_data_n, tx_data_n;
    logic                  wr_en_n, rd_en_n, tx_vld_n, err_n;
    logic                  tmo;

`ifdef FRAME_TIMEOUT_EN
    logic tmr_run;

    assign tmr_run = (state == WR_ADDR)
                  || (state == WR_DATA)
                  || (state == RD_ADDR);

    uart_cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .run    (tmr_run),
        .clr    (RX_D_VLD),
        .expired(tmo)
    );
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            wr_addr    <= '0;
            RF_Address <= '0;
            RF_WrEn    <= 1'b0;
            RF_WrData  <= '0;
            RF_RdEn    <= 1'b0;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            Cmd_Err    <= 1'b0;
        end else begin
            state      <= state_n;
            wr_addr    <= wr_addr_n;
            RF_Address <= rf_addr_n;
            RF_WrEn    <= wr_en_n;
            RF_WrData  <= wr_data_n;
            RF_RdEn    <= rd_en_n;
            TX_P_DATA  <= tx_data_n;
            TX_D_VLD   <= tx_vld_n;
            Cmd_Err    <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        wr_addr_n = wr_addr;
        rf_addr_n = RF_Address;
        wr_data_n = RF_WrData;
        tx_data_n = TX_P_DATA;
        wr_en_n   = 1'b0;
        rd_en_n   = 1'b0;
        tx_vld_n  = 1'b0;
        err_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WIDTH'(WR_CMD)) begin
                        state_n = WR_ADDR;
                    end else if (RX_P_DATA == WIDTH'(RD_CMD)) begin
                        state_n = RD_ADDR;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    wr_addr_n = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_n   = WR_DATA;
                end else if (tmo) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_n   = 1'b1;
                    rf_addr_n = wr_addr;
                    wr_data_n = RX_P_DATA;
                    state_n   = IDLE;
                end else if (tmo) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rd_en_n   = 1'b1;
                    rf_addr_n = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_n   = RD_WAIT;
                end else if (tmo) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            RD_WAIT: begin
                err_n = RX_D_VLD;
                if (RF_RdData_Valid) begin
                    tx_data_n = RF_RdData;
                    state_n   = TX_SEND;
                end
            end
            TX_SEND: begin
                // Bytes arriving while the reply is pending are discarded.
                err_n = RX_D_VLD;
                if (!TX_Busy) begin
                    tx_vld_n = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Self-checking bench for uart_rx_cmd_ctrl with a strobe scoreboard.
module tb_uart_rx_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [3:0] RF_Address;
    logic       RF_WrEn;
    logic [7:0] RF_WrData;
    logic       RF_RdEn;
    logic [7:0] RF_RdData;
    logic       RF_RdData_Valid;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       TX_Busy;
    logic       Cmd_Err;

    int checks   = 0;
    int failures = 0;
    int n_err    = 0;

    logic [11:0] wr_q[$];
    logic [3:0]  rd_q[$];
    logic [7:0]  tx_q[$];

    always #5 CLK = ~CLK;

    uart_rx_cmd_ctrl #(
        .WIDTH         (8),
        .ADDR_WIDTH    (4),
        .WR_CMD        (8'hAA),
        .RD_CMD        (8'hBB),
        .TIMEOUT_CYCLES(16'd100)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .RX_P_DATA      (RX_P_DATA),
        .RX_D_VLD       (RX_D_VLD),
        .RF_Address     (RF_Address),
        .RF_WrEn        (RF_WrEn),
        .RF_WrData      (RF_WrData),
        .RF_RdEn        (RF_RdEn),
        .RF_RdData      (RF_RdData),
        .RF_RdData_Valid(RF_RdData_Valid),
        .TX_P_DATA      (TX_P_DATA),
        .TX_D_VLD       (TX_D_VLD),
        .TX_Busy        (TX_Busy),
        .Cmd_Err        (Cmd_Err)
    );

    // Scoreboard: every strobe must match the oldest expected entry.
    always @(negedge CLK) begin
        if (RST) begin
            if (RF_WrEn) begin
                logic [11:0] e;
                checks++;
                if (wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_wr unexpected addr=%h data=%h",
                             RF_Address, RF_WrData);
                end else begin
                    e = wr_q.pop_front();
                    if ({RF_Address, RF_WrData} !== e) begin
                        failures++;
                        $display("FAIL sb_wr got=%h exp=%h",
                                 {RF_Address, RF_WrData}, e);
                    end
                end
            end
            if (RF_RdEn) begin
                logic [3:0] e;
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_rd unexpected addr=%h", RF_Address);
                end else begin
                    e = rd_q.pop_front();
                    if (RF_Address !== e) begin
                        failures++;
                        $display("FAIL sb_rd got=%h exp=%h", RF_Address, e);
                    end
                end
            end
            if (TX_D_VLD) begin
                logic [7:0] e;
                checks++;
                if (tx_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_tx unexpected data=%h", TX_P_DATA);
                end else begin
                    e = tx_q.pop_front();
                    if (TX_P_DATA !== e) begin
                        failures++;
                        $display("FAIL sb_tx got=%h exp=%h", TX_P_DATA, e);
                    end
                end
            end
            if (Cmd_Err) n_err++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK);
        #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic test_reset();
        RST             = 1'b0;
        RX_P_DATA       = '0;
        RX_D_VLD        = 1'b0;
        RF_RdData       = '0;
        RF_RdData_Valid = 1'b0;
        TX_Busy         = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({RF_Address, RF_WrEn, RF_WrData, RF_RdEn,
             TX_P_DATA, TX_D_VLD, Cmd_Err} !== 31'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {RF_Address, RF_WrEn, RF_WrData, RF_RdEn,
                      TX_P_DATA, TX_D_VLD, Cmd_Err});
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    task automatic test_write(input logic [7:0] a, input logic [7:0] d);
        int e0;
        e0 = n_err;
        wr_q.push_back({a[3:0], d});
        send_byte(8'hAA);
        send_byte(a);
        send_byte(d);
        @(negedge CLK);
        checks++;
        if (RF_WrEn !== 1'b1 || RF_Address !== a[3:0]
            || RF_WrData !== d) begin
            failures++;
            $display("FAIL write_strobe got=%b/%h/%h exp=1/%h/%h",
                     RF_WrEn, RF_Address, RF_WrData, a[3:0], d);
        end
        @(negedge CLK);
        checks++;
        if (RF_WrEn !== 1'b0 || RF_Address !== a[3:0]
            || RF_WrData !== d) begin
            failures++;
            $display("FAIL write_hold got=%b/%h/%h exp=0/%h/%h",
                     RF_WrEn, RF_Address, RF_WrData, a[3:0], d);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (n_err != e0) begin
            failures++;
            $display("FAIL write_no_err got=%0d exp=%0d", n_err, e0);
        end
    endtask

    // mode 0: clean, 1: stray byte in RD_WAIT, 2: stray byte with data
    task automatic test_read(input logic [7:0] a, input logic [7:0] d,
                             input int busy, input int mode);
        int  e0;
        bit  early;
        e0 = n_err;
        rd_q.push_back(a[3:0]);
        tx_q.push_back(d);
        TX_Busy = (busy > 0);
        send_byte(8'hBB);
        send_byte(a);
        @(negedge CLK);
        checks++;
        if (RF_RdEn !== 1'b1 || RF_Address !== a[3:0]) begin
            failures++;
            $display("FAIL read_strobe got=%b/%h exp=1/%h",
                     RF_RdEn, RF_Address, a[3:0]);
        end
        if (mode == 1) begin
            send_byte(8'h22);
            @(negedge CLK);
            checks++;
            if (Cmd_Err !== 1'b1) begin
                failures++;
                $display("FAIL drop_err got=%b exp=1", Cmd_Err);
            end
        end
        repeat (2) @(posedge CLK);
        #1;
        RF_RdData       = d;
        RF_RdData_Valid = 1'b1;
        if (mode == 2) begin
            RX_P_DATA = 8'h22;
            RX_D_VLD  = 1'b1;
        end
        @(posedge CLK);
        #1;
        RF_RdData_Valid = 1'b0;
        RX_D_VLD        = 1'b0;
        RF_RdData       = 8'h00;
        @(negedge CLK);
        if (mode == 2) begin
            checks++;
            if (Cmd_Err !== 1'b1) begin
                failures++;
                $display("FAIL drop_same_cycle_err got=%b exp=1", Cmd_Err);
            end
        end
        checks++;
        if (TX_D_VLD !== 1'b0) begin
            failures++;
            $display("FAIL tx_not_yet got=%b exp=0", TX_D_VLD);
        end
        if (busy > 0) begin
            early = 1'b0;
            for (int i = 0; i < busy; i++) begin
                @(negedge CLK);
                if (TX_D_VLD !== 1'b0) early = 1'b1;
            end
            checks++;
            if (early) begin
                failures++;
                $display("FAIL tx_while_busy got=1 exp=0");
            end
            @(posedge CLK);
            #1;
            TX_Busy = 1'b0;
            @(negedge CLK);
            checks++;
            if (TX_D_VLD !== 1'b0) begin
                failures++;
                $display("FAIL tx_busy_fall got=%b exp=0", TX_D_VLD);
            end
        end
        @(negedge CLK);
        checks++;
        if (TX_D_VLD !== 1'b1 || TX_P_DATA !== d) begin
            failures++;
            $display("FAIL tx_send got=%b/%h exp=1/%h",
                     TX_D_VLD, TX_P_DATA, d);
        end
        @(negedge CLK);
        checks++;
        if (TX_D_VLD !== 1'b0 || TX_P_DATA !== d) begin
            failures++;
            $display("FAIL tx_hold got=%b/%h exp=0/%h",
                     TX_D_VLD, TX_P_DATA, d);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (n_err != e0 + ((mode != 0) ? 1 : 0)) begin
            failures++;
            $display("FAIL read_err_count got=%0d exp=%0d",
                     n_err - e0, (mode != 0) ? 1 : 0);
        end
    endtask

    task automatic test_bad_opcode();
        send_byte(8'h11);
        @(negedge CLK);
        checks++;
        if (Cmd_Err !== 1'b1 || RF_WrEn !== 1'b0 || RF_RdEn !== 1'b0) begin
            failures++;
            $display("FAIL bad_opcode got=%b%b%b exp=100",
                     Cmd_Err, RF_WrEn, RF_RdEn);
        end
        @(negedge CLK);
        checks++;
        if (Cmd_Err !== 1'b0) begin
            failures++;
            $display("FAIL err_single_pulse got=%b exp=0", Cmd_Err);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hAA);
        send_byte(8'h05);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({RF_Address, RF_WrEn, RF_WrData, RF_RdEn,
             TX_P_DATA, TX_D_VLD, Cmd_Err} !== 31'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h exp=0",
                     {RF_Address, RF_WrEn, RF_WrData, RF_RdEn,
                      TX_P_DATA, TX_D_VLD, Cmd_Err});
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        send_byte(8'h3C);
        @(negedge CLK);
        checks++;
        if (Cmd_Err !== 1'b1 || RF_WrEn !== 1'b0) begin
            failures++;
            $display("FAIL frame_discarded got=%b%b exp=10",
                     Cmd_Err, RF_WrEn);
        end
    endtask

`ifdef FRAME_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        send_byte(8'hAA);
        while (!seen && n < 300) begin
            @(negedge CLK);
            n++;
            if (Cmd_Err === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != 101) begin
            failures++;
            $display("FAIL timeout_err seen=%b cycles=%0d exp=101", seen, n);
        end
        test_write(8'h01, 8'hFF);
    endtask
`endif

    initial begin
        test_reset();
        test_write(8'h05, 8'h3C);
        test_write(8'hF9, 8'hC3);
        test_read(8'h07, 8'h5A, 0, 0);
        test_read(8'h03, 8'hA5, 20, 0);
        test_bad_opcode();
        test_read(8'h0B, 8'h3E, 0, 1);
        test_read(8'hEC, 8'h81, 3, 2);
        test_write(8'h0F, 8'h00);
        test_reset_mid_frame();
`ifdef FRAME_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge CLK);
        checks++;
        if (wr_q.size() + rd_q.size() + tx_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d/%0d/%0d exp=0/0/0",
                     wr_q.size(), rd_q.size(), tx_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_cmd_ctrl.md
Name: uart_rx_cmd_ctrl

Overview:
- Command sequencer behind the UART receiver. Consumes validated bytes (P_DATA plus a one-cycle Data_Valid pulse) and decodes the byte stream into register-file write and read transactions.
- For reads, hands the returned data to the UART transmitter.
- Sits between the UART Rx top, the system register file and the UART Tx top.

Parameters:
- WIDTH, 8: UART data byte width.
- ADDR_WIDTH, 4: register-file address width; taken from the LSBs of the address byte, upper bits ignored.
- WR_CMD, 8'hAA: write-command opcode.
- RD_CMD, 8'hBB: read-command opcode.
- TIMEOUT_CYCLES, 16'd50000: inter-byte timeout in CLK cycles; used only with FRAME_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous active-low reset
- RX_P_DATA  in  WIDTH  received byte; valid only with RX_D_VLD
- RX_D_VLD  in  1  one-cycle pulse, byte valid
- RF_Address  out  ADDR_WIDTH  register-file address
- RF_WrEn  out  1  one-cycle write strobe
- RF_WrData  out  WIDTH  write data
- RF_RdEn  out  1  one-cycle read strobe
- RF_RdData  in  WIDTH  read data
- RF_RdData_Valid  in  1  read data valid pulse
- TX_P_DATA  out  WIDTH  byte to transmitter
- TX_D_VLD  out  1  one-cycle transmit request
- TX_Busy  in  1  transmitter busy
- Cmd_Err  out  1  one-cycle pulse: bad opcode, dropped byte or timeout

Behaviour:
- Reset (RST low, asynchronous): state IDLE; all outputs, including data/address registers, 0. Any partial frame is discarded.
- All outputs are registered. Strobes are high for exactly one cycle.

State machine:
- IDLE
  - RX_D_VLD with byte==WR_CMD -> WR_ADDR.
  - RX_D_VLD with byte==RD_CMD -> RD_ADDR.
  - Any other byte -> stay in IDLE; Cmd_Err=1 next cycle.
- WR_ADDR: on RX_D_VLD, latch byte[ADDR_WIDTH-1:0] -> WR_DATA.
- WR_DATA: on RX_D_VLD, next cycle RF_WrEn=1, RF_Address=latched address, RF_WrData=byte -> IDLE.
- RD_ADDR: on RX_D_VLD, next cycle RF_RdEn=1, RF_Address=byte[ADDR_WIDTH-1:0] -> RD_WAIT.
- RD_WAIT: on RF_RdData_Valid, latch RF_RdData into TX_P_DATA -> TX_SEND. No timeout; the register file must always answer.
- TX_SEND: while TX_Busy=1, hold. When TX_Busy=0, next cycle TX_D_VLD=1 with TX_P_DATA stable -> IDLE.

Latency:
- Write: RF_WrEn appears 1 cycle after the data-byte RX_D_VLD.
- Read: RF_RdEn appears 1 cycle after the address-byte RX_D_VLD.

Boundary conditions:
- RX_D_VLD in RD_WAIT or TX_SEND: byte dropped, Cmd_Err pulse, state unchanged.
- RX_D_VLD and RF_RdData_Valid in the same cycle in RD_WAIT: data latched, byte dropped, Cmd_Err pulse.
- Address byte upper bits (above ADDR_WIDTH): ignored silently.
- RF_Address and RF_WrData hold their last values between strobes.
- TX_P_DATA holds until the next read.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- Defined:
  - A counter runs in WR_ADDR, WR_DATA and RD_ADDR. It clears on every RX_D_VLD and on each state entry.
  - When the count reaches TIMEOUT_CYCLES-1 with no byte, state -> IDLE and Cmd_Err pulses once.
  - No RF strobe is issued.
  - The counter is held at 0 in all other states.
- Not defined: no counter logic; the FSM waits indefinitely for the next byte.

Decomposition:
- Shared package uart_sys_pkg:
  - state-encoding localparams (3-bit: IDLE=000, WR_ADDR=001, WR_DATA=010, RD_ADDR=011, RD_WAIT=100, TX_SEND=101)
  - default opcode constants
- One natural sub-module: uart_cmd_timer, the timeout counter, instantiated only under FRAME_TIMEOUT_EN.

Test Plan:
- Write: bytes AA,05,3C -> RF_WrEn single pulse, RF_Address=5, RF_WrData=3C, one cycle after the third RX_D_VLD; Cmd_Err stays 0.
- Read: bytes BB,07 -> RF_RdEn pulse with RF_Address=7. RF returns 5A after 2 cycles, TX_Busy=0 -> TX_D_VLD single pulse with TX_P_DATA=5A; state back to IDLE.
- Busy transmitter: read as above with TX_Busy=1 for 20 cycles -> TX_D_VLD asserted exactly 1 cycle after TX_Busy falls, never earlier.
- Bad opcode and drop: byte 11 in IDLE -> Cmd_Err pulse, no RF strobe. Then byte 22 during RD_WAIT -> Cmd_Err pulse, read completes normally.
- Reset mid-frame: AA,05, then RST low for 1 cycle, then 3C -> no RF_WrEn, Cmd_Err pulse for 3C (bad opcode in IDLE), all outputs 0 during reset.
- FRAME_TIMEOUT_EN with TIMEOUT_CYCLES=100: AA then silence -> Cmd_Err pulse after 100 cycles, state IDLE. A following AA,01,FF performs a normal write.
